// File: rtl/rx_frame_sr.sv
// UART receive frame capture: shifts serial bits into a frame register, checks stop bits
// and publishes completed words through a data_ready/data_read holding register.
// Optional parity slot and parity_error output when RX_PARITY_EN is defined.
module rx_frame_sr #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 frame_start,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] packet_data,
  output logic                 stop_bit,
  output logic                 frame_done,
  output logic                 framing_error,
  output logic                 data_ready,
  output logic                 overrun_error
`ifdef RX_PARITY_EN
  ,
  output logic                 parity_error
`endif
);

`ifdef RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = DATA_BITS + PAR + STOP_BITS;
  localparam int CW    = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME);

  logic [FRAME-1:0]     sr;
  logic [CW-1:0]        cnt;
  logic                 done_pend;
  logic                 shift_en;
  logic [DATA_BITS-1:0] field;
  logic                 stop_all;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    shift_en = shift_strobe && !frame_start && (cnt != FULL);
    field    = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      field[i] = (MSB_FIRST != 0) ? sr[DATA_BITS-1-i] : sr[i];
    end
    stop_all = &sr[FRAME-1 -: STOP_BITS];
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the shift register is reset to the idle-line value (all 1s), not left uninitialised.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr        <= '1;
      cnt       <= '0;
      done_pend <= 1'b0;
    end else begin
      done_pend <= shift_en && (cnt == LAST);
      if (frame_start) begin
        sr  <= '1;
        cnt <= '0;
      end else if (shift_en) begin
        sr  <= {serial_in, sr[FRAME-1:1]};
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Publish one cycle after the last bit lands; a read in the same cycle suppresses overrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      packet_data   <= '0;
      stop_bit      <= 1'b0;
      frame_done    <= 1'b0;
      framing_error <= 1'b0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
`ifdef RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
    end else begin
      frame_done <= done_pend;
      if (done_pend) begin
        packet_data   <= field;
        stop_bit      <= stop_all;
        framing_error <= ~stop_all;
        data_ready    <= 1'b1;
        overrun_error <= data_ready & ~data_read;
`ifdef RX_PARITY_EN
        parity_error  <= ((^sr[DATA_BITS:0]) != (PARITY_ODD != 0));
`endif
      end else if (data_read && data_ready) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end

`ifndef RX_PARITY_EN
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

endmodule

// File: tb/tb_rx_frame_sr.sv
// Self-checking bench for rx_frame_sr: a default instance and a 5-bit/2-stop/MSB-first
// instance, driven with directed and random frames against a frame-level reference model.
module tb_rx_frame_sr;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       fs [2];
  logic       ss [2];
  logic       si [2];
  logic       dr [2];
  logic [7:0] pd0;
  logic [4:0] pd1;
  logic       stp [2];
  logic       fd  [2];
  logic       fe  [2];
  logic       rdy [2];
  logic       ovr [2];
  logic       pe  [2];

  int vectors     = 0;
  int miscompares = 0;

  int exp_pd   [2];
  bit exp_stop [2];
  bit exp_fe   [2];
  bit exp_rdy  [2];
  bit exp_ovr  [2];
  bit exp_pe   [2];

  always #5 clk = ~clk;

  rx_frame_sr u_a (
    .clk(clk), .n_rst(n_rst), .frame_start(fs[0]), .shift_strobe(ss[0]),
    .serial_in(si[0]), .data_read(dr[0]), .packet_data(pd0), .stop_bit(stp[0]),
    .frame_done(fd[0]), .framing_error(fe[0]), .data_ready(rdy[0]),
    .overrun_error(ovr[0])
`ifdef RX_PARITY_EN
    , .parity_error(pe[0])
`endif
  );

  rx_frame_sr #(.DATA_BITS(5), .STOP_BITS(2), .MSB_FIRST(1), .PARITY_ODD(0)) u_b (
    .clk(clk), .n_rst(n_rst), .frame_start(fs[1]), .shift_strobe(ss[1]),
    .serial_in(si[1]), .data_read(dr[1]), .packet_data(pd1), .stop_bit(stp[1]),
    .frame_done(fd[1]), .framing_error(fe[1]), .data_ready(rdy[1]),
    .overrun_error(ovr[1])
`ifdef RX_PARITY_EN
    , .parity_error(pe[1])
`endif
  );

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [8:0] get_pd(int sel);
    return (sel != 0) ? {4'b0, pd1} : {1'b0, pd0};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      exp_pd[s] = 0; exp_stop[s] = 0; exp_fe[s] = 0;
      exp_rdy[s] = 0; exp_ovr[s] = 0; exp_pe[s] = 0;
    end
  endtask

  task automatic check_all(string tag, int sel, bit exp_fd);
    chk({tag, "_fd"},   16'(fd[sel]),    16'(exp_fd));
    chk({tag, "_pd"},   16'(get_pd(sel)), 16'(exp_pd[sel]));
    chk({tag, "_stop"}, 16'(stp[sel]),   16'(exp_stop[sel]));
    chk({tag, "_fe"},   16'(fe[sel]),    16'(exp_fe[sel]));
    chk({tag, "_rdy"},  16'(rdy[sel]),   16'(exp_rdy[sel]));
    chk({tag, "_ovr"},  16'(ovr[sel]),   16'(exp_ovr[sel]));
`ifdef RX_PARITY_EN
    chk({tag, "_pe"},   16'(pe[sel]),    16'(exp_pe[sel]));
`endif
  endtask

  // Serialise one frame (data, optional parity, stops) and check the published result.
  task automatic send(int sel, int data, bit par, bit [1:0] stops, bit do_start, bit rd,
                      string tag);
    bit q[$];
    int db = (sel != 0) ? 5 : 8;
    int sb = (sel != 0) ? 2 : 1;
    bit s_all;
    q = {};
    for (int i = 0; i < db; i++)
      q.push_back(bit'((data >> ((sel != 0) ? (db - 1 - i) : i)) & 1));
`ifdef RX_PARITY_EN
    q.push_back(par);
`endif
    for (int i = 0; i < sb; i++) q.push_back(stops[i]);
    if (do_start) begin
      @(negedge clk); fs[sel] = 1'b1; ss[sel] = 1'b0;
    end
    foreach (q[i]) begin
      @(negedge clk); fs[sel] = 1'b0; ss[sel] = 1'b1; si[sel] = q[i];
    end
    @(negedge clk); ss[sel] = 1'b0; dr[sel] = rd;
    chk({tag, "_pre_fd"}, 16'(fd[sel]), 16'd0);
    s_all          = (sb == 2) ? (stops[0] & stops[1]) : stops[0];
    exp_ovr[sel]   = exp_rdy[sel] & ~rd;
    exp_rdy[sel]   = 1'b1;
    exp_pd[sel]    = data;
    exp_stop[sel]  = s_all;
    exp_fe[sel]    = ~s_all;
    exp_pe[sel]    = ((($countones(data) + int'(par)) % 2) != 0);
    @(negedge clk); dr[sel] = 1'b0;
    check_all(tag, sel, 1'b1);
    @(negedge clk);
    chk({tag, "_post_fd"}, 16'(fd[sel]), 16'd0);
  endtask

  task automatic read(int sel, string tag);
    @(negedge clk); dr[sel] = 1'b1;
    if (exp_rdy[sel]) begin
      exp_rdy[sel] = 1'b0;
      exp_ovr[sel] = 1'b0;
    end
    @(negedge clk); dr[sel] = 1'b0;
    check_all(tag, sel, 1'b0);
  endtask

  task automatic partial(int sel, int n);
    @(negedge clk); fs[sel] = 1'b1; ss[sel] = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); fs[sel] = 1'b0; ss[sel] = 1'b1; si[sel] = 1'($urandom_range(0, 1));
    end
    @(negedge clk); ss[sel] = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      fs[s] = 1'b0; ss[s] = 1'b0; si[s] = 1'b1; dr[s] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_all("rst_a", 0, 1'b0);
    check_all("rst_b", 1, 1'b0);
    n_rst = 1'b1;

    // Default frame 0xA5, then bad stop bit, then good frame clears framing_error.
    send(0, 'hA5, 1'b0, 2'b11, 1'b1, 1'b0, "a5_good");
    read(0, "a5_read");
    send(0, 'hA5, 1'b0, 2'b00, 1'b1, 1'b0, "a5_badstop");
    read(0, "badstop_read");
    send(0, 'h3C, 1'b0, 2'b11, 1'b1, 1'b0, "3c_good");
    read(0, "3c_read");

    // Overrun, then clear; a read while empty changes nothing.
    send(0, 'h11, 1'b0, 2'b11, 1'b1, 1'b0, "ovr_11");
    send(0, 'h22, 1'b0, 2'b11, 1'b1, 1'b0, "ovr_22");
    read(0, "ovr_read");
    read(0, "empty_read");

    // MSB-first, 5 data bits, two stop bits.
    send(1, 'b10011, 1'b0, 2'b11, 1'b1, 1'b0, "msb_good");
    read(1, "msb_read");
    send(1, 'b10011, 1'b0, 2'b01, 1'b1, 1'b0, "msb_stop2bad");
    read(1, "msb_read2");

    // frame_start wins over a coincident strobe; counter restarts cleanly.
    partial(0, 4);
    @(negedge clk); fs[0] = 1'b1; ss[0] = 1'b1; si[0] = 1'b0;
    send(0, 'h5A, 1'b0, 2'b11, 1'b0, 1'b0, "restart_5a");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ss[0] = 1'b1; si[0] = 1'($urandom_range(0, 1));
    end
    @(negedge clk); ss[0] = 1'b0;
    @(negedge clk);
    check_all("extra_strobes", 0, 1'b0);
    read(0, "5a_read");

    // Completion coinciding with data_read: no new overrun, old overrun cleared.
    send(0, 'h44, 1'b0, 2'b11, 1'b1, 1'b0, "coinc_44");
    send(0, 'h55, 1'b0, 2'b11, 1'b1, 1'b0, "coinc_55_ovr");
    send(0, 'h66, 1'b0, 2'b11, 1'b1, 1'b1, "coinc_66_rd");
    read(0, "coinc_read");

`ifdef RX_PARITY_EN
    send(0, 'h07, 1'b1, 2'b11, 1'b1, 1'b0, "par_ok");
    chk("par_ok_const", 16'(pe[0]), 16'd0);
    read(0, "par_ok_read");
    send(0, 'h07, 1'b0, 2'b11, 1'b1, 1'b0, "par_bad");
    chk("par_bad_const", 16'(pe[0]), 16'd1);
    read(0, "par_bad_read");
`endif

    // Reset mid-frame clears everything and discards the partial frame.
    send(0, 'h96, 1'b0, 2'b00, 1'b1, 1'b0, "pre_rst");
    partial(0, 3);
    @(negedge clk); fs[0] = 1'b1; ss[0] = 1'b0;
    @(negedge clk); fs[0] = 1'b0; ss[0] = 1'b1; si[0] = 1'b0;
    @(negedge clk); ss[0] = 1'b1; si[0] = 1'b1;
    @(negedge clk); ss[0] = 1'b0;
    #1 n_rst = 1'b0;
    model_reset();
    #1 check_all("midrst_a", 0, 1'b0);
    check_all("midrst_b", 1, 1'b0);
    @(negedge clk); n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all("after_rst", 0, 1'b0);
    end
    send(0, 'hC3, 1'b0, 2'b11, 1'b0, 1'b0, "post_rst_c3");
    read(0, "post_rst_read");

    // Random frames on both instances with random read behaviour.
    for (int n = 0; n < 40; n++) begin
      int sel;
      int data;
      sel  = int'($urandom_range(0, 1));
      data = int'($urandom_range(0, (sel != 0) ? 31 : 255));
      send(sel, data, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11,
           1'b1, ($urandom_range(0, 3) == 0), "rnd");
      if ($urandom_range(0, 1) == 1) read(sel, "rnd_read");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
